// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM for the MIPS-1 core: fetch/decode/execute/memory/
// write-back sequencing, bus wait-state stalls, multiply/divide wait and halt.
module mips_multicycle_control #(
  parameter int ALUCTL_W      = 4,
  parameter int MULDIV_CYCLES = 33
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          rt,
  input  logic                waitrequest,
  input  logic                jr_target_zero,
  output logic [2:0]          state,
  output logic                active,
  output logic                ir_write,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                hilo_write,
  output logic                muldiv_start,
  output logic                mem_addr_sel,
  output logic                alu_src,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [ALUCTL_W-1:0] alu_control
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_MULDIV,
    C_MTHILO, C_JR, C_BRANCH, C_LINK, C_JALR
  } cls_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                         ALU_SRA = 4'd9, ALU_LUI = 4'd10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  cls_t             cls;
  logic [3:0]       alu_code;
  logic             imm_src;

  // Instruction class, ALU operation and operand source from the IR fields.
  always_comb begin
    cls      = C_NOP;
    alu_code = ALU_ADD;
    imm_src  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h04: begin cls = C_ALU_R; alu_code = ALU_SLL; end
          6'h02, 6'h06: begin cls = C_ALU_R; alu_code = ALU_SRL; end
          6'h03, 6'h07: begin cls = C_ALU_R; alu_code = ALU_SRA; end
          6'h08:        cls = C_JR;
          6'h09:        cls = C_JALR;
          6'h11, 6'h13: cls = C_MTHILO;
          6'h18, 6'h19, 6'h1A, 6'h1B: cls = C_MULDIV;
          6'h20, 6'h21: begin cls = C_ALU_R; alu_code = ALU_ADD; end
          6'h22, 6'h23: begin cls = C_ALU_R; alu_code = ALU_SUB; end
          6'h24:        begin cls = C_ALU_R; alu_code = ALU_AND; end
          6'h25:        begin cls = C_ALU_R; alu_code = ALU_OR;  end
          6'h26:        begin cls = C_ALU_R; alu_code = ALU_XOR; end
          6'h2A:        begin cls = C_ALU_R; alu_code = ALU_SLT; end
          6'h2B:        begin cls = C_ALU_R; alu_code = ALU_SLTU; end
          default:      cls = C_NOP;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: begin cls = C_BRANCH; alu_code = ALU_SLT; end
          5'h10, 5'h11: begin cls = C_LINK;   alu_code = ALU_SLT; end
          default:      cls = C_NOP;
        endcase
      end
      6'h02:        cls = C_BRANCH;
      6'h03:        cls = C_LINK;
      6'h04, 6'h05: begin cls = C_BRANCH; alu_code = ALU_SUB; end
      6'h06, 6'h07: begin cls = C_BRANCH; alu_code = ALU_SLT; end
      6'h08, 6'h09: begin cls = C_ALU_I; alu_code = ALU_ADD;  imm_src = 1'b1; end
      6'h0A:        begin cls = C_ALU_I; alu_code = ALU_SLT;  imm_src = 1'b1; end
      6'h0B:        begin cls = C_ALU_I; alu_code = ALU_SLTU; imm_src = 1'b1; end
      6'h0C:        begin cls = C_ALU_I; alu_code = ALU_AND;  imm_src = 1'b1; end
      6'h0D:        begin cls = C_ALU_I; alu_code = ALU_OR;   imm_src = 1'b1; end
      6'h0E:        begin cls = C_ALU_I; alu_code = ALU_XOR;  imm_src = 1'b1; end
      6'h0F:        begin cls = C_ALU_I; alu_code = ALU_LUI;  imm_src = 1'b1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin cls = C_LOAD; imm_src = 1'b1; end
      6'h28, 6'h29, 6'h2B:               begin cls = C_STORE; imm_src = 1'b1; end
      default: cls = C_NOP;
    endcase
  end

  // Next state, multiply/divide counter and all datapath controls; every
  // output is forced low while reset is held.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    hilo_write   = 1'b0;
    muldiv_start = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src      = 1'b0;
    reg_dst      = 2'd0;
    mem_to_reg   = 2'd0;
    alu_control  = '0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (!waitrequest) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        pc_write    = 1'b1;
        alu_control = ALUCTL_W'(alu_code);
        alu_src     = imm_src;
        case (cls)
          C_ALU_R, C_ALU_I, C_LINK, C_JALR: state_d = S_WB;
          C_LOAD, C_STORE:                  state_d = S_MEM;
          C_MULDIV: begin
            muldiv_start = 1'b1;
            cnt_d        = CNT_LOAD;
            state_d      = S_MULDIV;
          end
          C_MTHILO: begin
            hilo_write = 1'b1;
            state_d    = S_FETCH;
          end
          C_JR:    state_d = jr_target_zero ? S_HALT : S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        mem_read     = (cls == C_LOAD);
        mem_write    = (cls == C_STORE);
        if (!waitrequest) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        case (cls)
          C_ALU_R: reg_dst = 2'd1;
          C_LOAD:  mem_to_reg = 2'd1;
          C_LINK:  begin reg_dst = 2'd2; mem_to_reg = 2'd2; end
          C_JALR:  begin reg_dst = 2'd1; mem_to_reg = 2'd2; end
          default: reg_dst = 2'd0;
        endcase
        state_d = S_FETCH;
      end
      S_MULDIV: begin
        if (cnt_q == '0) begin
          hilo_write = 1'b1;
          state_d    = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    active_d = (state_d != S_HALT);
    if (!reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      hilo_write   = 1'b0;
      muldiv_start = 1'b0;
      mem_addr_sel = 1'b0;
      alu_src      = 1'b0;
      reg_dst      = 2'd0;
      mem_to_reg   = 2'd0;
      alu_control  = '0;
    end
  end

  // State, counter and active flag; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign state  = state_q;
  assign active = active_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the stimulus pushes the
// expected per-cycle control vector, the monitor pops and compares it.
module tb_mips_multicycle_control;

  localparam int ALUCTL_W = 4;
  localparam int MC       = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt = '0;
  logic waitrequest = 1'b0;
  logic jr_target_zero = 1'b0;
  logic [2:0] state;
  logic active, ir_write, pc_write, mem_read, mem_write, reg_write;
  logic hilo_write, muldiv_start, mem_addr_sel, alu_src;
  logic [1:0] reg_dst, mem_to_reg;
  logic [ALUCTL_W-1:0] alu_control;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ALUCTL_W(ALUCTL_W), .MULDIV_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt(rt),
    .waitrequest(waitrequest), .jr_target_zero(jr_target_zero),
    .state(state), .active(active), .ir_write(ir_write), .pc_write(pc_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .hilo_write(hilo_write), .muldiv_start(muldiv_start),
    .mem_addr_sel(mem_addr_sel), .alu_src(alu_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_control(alu_control)
  );

  // {state, active, ir, pc, mr, mw, rw, hw, ms, mas, as, reg_dst, mem_to_reg, alu}
  logic [20:0] act_v;
  assign act_v = {state, active, ir_write, pc_write, mem_read, mem_write,
                  reg_write, hilo_write, muldiv_start, mem_addr_sel, alu_src,
                  reg_dst, mem_to_reg, alu_control};

  logic [20:0] exp_q[$];
  string       name_q[$];
  int tests_run = 0;
  int failed    = 0;

  function automatic logic [20:0] ev(input logic [2:0] st, input logic act,
      input logic ir, input logic pc, input logic mr, input logic mw,
      input logic rw, input logic hw, input logic ms, input logic mas,
      input logic as, input logic [1:0] rd, input logic [1:0] m2r,
      input logic [3:0] alu);
    return {st, act, ir, pc, mr, mw, rw, hw, ms, mas, as, rd, m2r, alu};
  endfunction

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input string n, input logic [20:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    opcode = op;
    funct  = fn;
    rt     = r;
  endtask

  // FETCH (with optional wait states) followed by DECODE.
  task automatic fd(input string n, input int waits, input logic a);
    waitrequest = 1'b1;
    for (int i = 0; i < waits; i++)
      step({n, "_fwait"}, ev(3'd0, a, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    waitrequest = 1'b0;
    step({n, "_fetch"}, ev(3'd0, a, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    step({n, "_decode"}, ev(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
  endtask

  // Monitor: compare the DUT outputs on every falling edge that has an expectation.
  initial begin
    logic [20:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests_run++;
        if (act_v !== e) begin
          failed++;
          $display("FAIL %s: got %b required %b", n, act_v, e);
        end
      end
    end
  end

  logic [20:0] z;

  initial begin
    z = ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0);
    instr(6'h0D, 6'h00, 5'h00);
    @(posedge clk);
    #1;
    step("rst0", z);
    step("rst1", z);
    reset = 1'b1;

    // ORI straight after reset release: 4 cycles, active rises after cycle 0
    fd("ori", 0, 1'b0);
    step("ori_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd3));
    step("ori_wb",   ev(3'd4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));

    // ADDU with two fetch wait states
    instr(6'h00, 6'h21, 5'h00);
    fd("addu", 2, 1'b1);
    step("addu_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    step("addu_wb",   ev(3'd4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 4'd0));

    // LW with three memory wait states
    instr(6'h23, 6'h00, 5'h00);
    fd("lw", 0, 1'b1);
    step("lw_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0));
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++)
      step("lw_mwait", ev(3'd3, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0));
    waitrequest = 1'b0;
    step("lw_mem", ev(3'd3, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0));
    step("lw_wb",  ev(3'd4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0));

    // SW: write only, no write-back
    instr(6'h2B, 6'h00, 5'h00);
    fd("sw", 0, 1'b1);
    step("sw_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0));
    step("sw_mem",  ev(3'd3, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0));

    // DIVU: MULDIV lasts MC cycles, hilo_write only in the last
    instr(6'h00, 6'h1B, 5'h00);
    fd("divu", 0, 1'b1);
    step("divu_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0));
    for (int i = 0; i < MC - 1; i++)
      step("divu_busy", ev(3'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    step("divu_done", ev(3'd5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0));

    // BLTZAL: SLT compare, unconditional link write to $31
    instr(6'h01, 6'h00, 5'h10);
    fd("bltzal", 0, 1'b1);
    step("bltzal_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd5));
    step("bltzal_wb",   ev(3'd4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd2, 2'd2, 4'd0));

    // BEQ: SUB, three cycles
    instr(6'h04, 6'h00, 5'h00);
    fd("beq", 0, 1'b1);
    step("beq_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd1));

    // MTHI: hilo_write in EXEC
    instr(6'h00, 6'h11, 5'h00);
    fd("mthi", 0, 1'b1);
    step("mthi_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0));

    // Undefined opcode runs as a NOP
    instr(6'h3F, 6'h00, 5'h00);
    fd("undef", 0, 1'b1);
    step("undef_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));

    // SW stalled in MEM, then reset pulsed: FETCH at once, no write
    instr(6'h2B, 6'h00, 5'h00);
    fd("sw2", 0, 1'b1);
    step("sw2_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0));
    waitrequest = 1'b1;
    step("sw2_mwait", ev(3'd3, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0));
    reset = 1'b0;
    step("rst_in_mem", z);
    reset = 1'b1;

    // JR to zero halts; HALT absorbs for 100 cycles
    instr(6'h00, 6'h08, 5'h00);
    jr_target_zero = 1'b1;
    fd("jr", 0, 1'b0);
    step("jr_exec", ev(3'd2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    for (int i = 0; i < 100; i++) begin
      waitrequest = i[0];
      step("halt", ev(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0));
    end

    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control FSM for the MIPS-1 CPU core: sequences every instruction through fetch, decode, execute, memory and write-back, and stalls on a bus wait-request and on the multi-cycle multiply/divide unit. Replaces the single-cycle opcode decoder and drives all datapath strobes, mux selects and the ALU operation code. Sits between the instruction register and the datapath; it also owns the halt condition and the `active` flag.

## Interface
- ALUCTL_W, 4: ALU control width, ≥4; codes zero-extended.
- MULDIV_CYCLES, 33: cycles spent in MULDIV, ≥2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- opcode  in  6  IR[31:26], stable from DECODE until the return to FETCH.
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16]; selects the REGIMM variant.
- waitrequest  in  1  memory bus stall.
- jr_target_zero  in  1  register rs == 0; sampled in EXEC.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULDIV=5, HALT=6.
- active  out  1  1 from the first edge after reset release until HALT.
- ir_write, pc_write, mem_read, mem_write, reg_write, hilo_write, muldiv_start  out  1 each  strobes.
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- alu_src  out  1  0=rt register, 1=extended immediate.
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  0=ALU, 1=memory, 2=link (PC+8).
- alu_control  out  ALUCTL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LUI.

## Operation
- State register with asynchronous reset to FETCH. While reset=0: state=0, active=0, all strobes 0, all selects 0.
- FETCH: mem_read=1, mem_addr_sel=0. Holds while waitrequest=1. The cycle with waitrequest=0 asserts ir_write=1 and goes to DECODE.
- DECODE: no strobes. Next state is EXEC.
- EXEC: alu_control and alu_src are decoded from opcode, funct and rt. pc_write=1 exactly once per instruction, in this cycle. Branch/delay-slot target selection is done in the datapath. Next state:
  - ALU R-type and immediate ops, LUI, JAL, JALR, BGEZAL, BLTZAL: WB.
  - Loads and stores: MEM.
  - MULT, MULTU, DIV, DIVU: MULDIV, with muldiv_start=1 in this cycle.
  - MTHI, MTLO: hilo_write=1, then FETCH.
  - JR with jr_target_zero=1: HALT. Other J, JR, branches: FETCH.
  - Undefined encodings: FETCH, executed as NOP (pc_write only).
- MEM: mem_addr_sel=1, with mem_read=1 for loads or mem_write=1 for stores. Holds while waitrequest=1. On release, loads go to WB and stores go to FETCH.
- WB: reg_write=1 for one cycle, then FETCH. Selects:
  - R-type: reg_dst=1.
  - Immediates and loads: reg_dst=0.
  - Links: reg_dst=2 (JALR: rd), mem_to_reg=2. Link writes are unconditional.
  - Loads: mem_to_reg=1.
- MULDIV: a down-counter loads MULDIV_CYCLES-1 on entry and decrements every cycle. At count 0: hilo_write=1, then FETCH. The counter width is $clog2(MULDIV_CYCLES).
- HALT: absorbing state; active=0 and all strobes 0 until reset.
- ALU mapping:
  - ADD: ADDU, ADDIU, loads, stores.
  - SUB: SUBU, BEQ, BNE.
  - SLT: BGEZ, BGTZ, BLEZ, BLTZ and the link variants.
  - Logic, shift and set ops map to their own code. Variable shifts take the shift amount from rs in the datapath.

## Timing
- Minimum cycles per instruction, with no wait states:
  - Branch/jump/MTxx: 3.
  - ALU op: 4.
  - Store: 4.
  - Load: 5.
  - MULT/DIV: 3 + MULDIV_CYCLES.
- Each waitrequest cycle in FETCH or MEM adds exactly one cycle. No strobe other than the held mem_read/mem_write is repeated while stalled.
- All outputs are a combinational function of state, the counter and the instruction fields. They settle within the cycle, and strobes are single-cycle except during a bus stall.
- Reset asserted mid-instruction (including MULDIV or a stalled MEM) forces FETCH immediately and drops every strobe. No partial write completes after the edge.
- active rises on the first rising clk edge with reset=1.

## Test plan
- Reset release, waitrequest=0: state 0→1→2, ir_write pulses in cycle 0, active=1 from cycle 1.
- ADDU (op 0, funct 0x21) with 2 FETCH wait cycles: FETCH lasts 3 cycles; EXEC has alu_control=0, alu_src=0; WB has reg_write=1, reg_dst=1, mem_to_reg=0; total 6 cycles.
- LW (op 0x23), MEM waitrequest for 3 cycles: mem_read held 4 cycles with mem_addr_sel=1; then WB with mem_to_reg=1, reg_dst=0. SW (op 0x2B): mem_write only, no WB.
- DIVU, MULDIV_CYCLES=5: muldiv_start pulses in EXEC; MULDIV lasts 5 cycles; hilo_write only in the last of them; back to FETCH.
- BLTZAL (op 1, rt 0x10): alu_control=5, then WB with reg_dst=2, mem_to_reg=2, reg_write=1.
- JR (funct 0x08) with jr_target_zero=1: HALT after EXEC, active=0, stays halted for 100 cycles. Reset pulsed in MEM: FETCH next cycle with no mem_write.
